// File: rtl/note_motion_fsm_pkg.sv
// Shared types for the note-driven motion controller: FSM state encoding
// and move direction.
package note_motion_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MOVE_L   = 2'd1,
    ST_MOVE_R   = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/note_classifier.sv
// Combinational note classifier: high codes move left, low non-zero codes
// move right, everything else (including rest) is dead.
module note_classifier
  import note_motion_fsm_pkg::*;
#(
  parameter int NOTE_W    = 6,
  parameter int LEFT_MIN  = 15,
  parameter int RIGHT_MAX = 7
) (
  input  logic [NOTE_W-1:0] note,
  output dir_t              cls
);

  localparam logic [NOTE_W-1:0] LMIN = NOTE_W'(LEFT_MIN);
  localparam logic [NOTE_W-1:0] RMAX = NOTE_W'(RIGHT_MAX);

  always_comb begin
    cls = DIR_NONE;
    if (note >= LMIN) begin
      cls = DIR_LEFT;
    end else if ((note != '0) && (note <= RMAX)) begin
      cls = DIR_RIGHT;
    end
  end

endmodule

// File: rtl/note_motion_fsm.sv
// Note-driven motion FSM: turns accepted notes into fixed-length left/right
// pulses separated by a cooldown, with a one-entry queue for notes seen while busy.
module note_motion_fsm
  import note_motion_fsm_pkg::*;
#(
  parameter int NOTE_W    = 6,
  parameter int LEFT_MIN  = 15,
  parameter int RIGHT_MAX = 7,
  parameter int PULSE_LEN = 4,
  parameter int COOLDOWN  = 2,
  parameter int CNT_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note_in,
  output logic              move_left,
  output logic              move_right,
  output logic              busy,
  output logic              pending,
  output logic              overwrite,
  output logic [CNT_W-1:0]  move_count
);

  localparam int TMR_W = $clog2(max2(PULSE_LEN, COOLDOWN)) + 1;
  localparam logic [TMR_W-1:0] PULSE_LD = TMR_W'(PULSE_LEN - 1);
  localparam logic [TMR_W-1:0] COOL_LD  = TMR_W'(COOLDOWN - 1);

  state_t             state, state_n;
  logic [TMR_W-1:0]   timer, timer_n;
  dir_t               pend_dir, pend_dir_n;
  logic               pending_n, overwrite_n;
  logic               cnt_inc;
  dir_t               go_dir;
  logic [NOTE_W-1:0]  last_note;
  logic               last_valid;
  dir_t               cls;
  logic               accept;

  note_classifier #(
    .NOTE_W   (NOTE_W),
    .LEFT_MIN (LEFT_MIN),
    .RIGHT_MAX(RIGHT_MAX)
  ) u_classifier (
    .note(note_in),
    .cls (cls)
  );

  // A held or repeated note only counts once; rests and dead notes never count.
  assign accept = note_valid && (cls != DIR_NONE) &&
                  (!last_valid || (note_in != last_note));

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_n     = state;
    timer_n     = timer;
    pending_n   = pending;
    pend_dir_n  = pend_dir;
    overwrite_n = 1'b0;
    cnt_inc     = 1'b0;
    go_dir      = DIR_NONE;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          go_dir    = cls;
          pending_n = 1'b0;
        end else if (pending) begin
          go_dir    = pend_dir;
          pending_n = 1'b0;
        end
      end
      ST_MOVE_L, ST_MOVE_R: begin
        if (timer == '0) begin
          state_n = ST_COOLDOWN;
          timer_n = COOL_LD;
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      ST_COOLDOWN: begin
        if (timer == '0) begin
          if (pending) begin
            go_dir    = pend_dir;
            pending_n = 1'b0;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          timer_n = timer - TMR_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (go_dir != DIR_NONE) begin
      state_n = (go_dir == DIR_LEFT) ? ST_MOVE_L : ST_MOVE_R;
      timer_n = PULSE_LD;
      cnt_inc = 1'b1;
    end

    // Consumption above already cleared pending_n, so a note landing on the
    // consuming edge refills the slot without flagging an overwrite.
    if (busy && accept) begin
      overwrite_n = pending_n;
      pending_n   = 1'b1;
      pend_dir_n  = cls;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      pending    <= 1'b0;
      pend_dir   <= DIR_NONE;
      overwrite  <= 1'b0;
      move_left  <= 1'b0;
      move_right <= 1'b0;
      move_count <= '0;
      last_note  <= '0;
      last_valid <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      pending    <= pending_n;
      pend_dir   <= pend_dir_n;
      overwrite  <= overwrite_n;
      move_left  <= (state_n == ST_MOVE_L);
      move_right <= (state_n == ST_MOVE_R);
      move_count <= move_count + {{(CNT_W-1){1'b0}}, cnt_inc};
      if (accept) begin
        last_note  <= note_in;
        last_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_note_motion_fsm.sv
// Directed bench for note_motion_fsm with default parameters.
module tb_note_motion_fsm;

  logic       clock = 1'b0;
  logic       reset;
  logic       note_valid;
  logic [5:0] note_in;
  logic       move_left, move_right, busy, pending, overwrite;
  logic [7:0] move_count;

  int total  = 0;
  int passed = 0;

  note_motion_fsm dut (
    .clock     (clock),
    .reset     (reset),
    .note_valid(note_valid),
    .note_in   (note_in),
    .move_left (move_left),
    .move_right(move_right),
    .busy      (busy),
    .pending   (pending),
    .overwrite (overwrite),
    .move_count(move_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    total++;
    assert (!(move_left && move_right)) passed++;
    else $error("FAIL excl left=%0b right=%0b required not both 1", move_left, move_right);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic send(input int note);
    note_valid = 1'b1;
    note_in    = 6'(note);
    tick();
    note_valid = 1'b0;
  endtask

  task automatic count_rises(input int n, output int lr, output int rr);
    logic pl, pr;
    lr = 0; rr = 0;
    pl = move_left; pr = move_right;
    for (int i = 0; i < n; i++) begin
      tick();
      if (move_left && !pl) lr++;
      if (move_right && !pr) rr++;
      pl = move_left; pr = move_right;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("idle_bound", int'(busy), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int lr, rr, lr2, rr2, ov;
    reset = 1'b1; note_valid = 1'b0; note_in = '0;
    tick(); tick();
    chk("rst_left", int'(move_left), 0);
    chk("rst_right", int'(move_right), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overwrite", int'(overwrite), 0);
    chk("rst_count", int'(move_count), 0);
    reset = 1'b0;
    tick();

    // Single-cycle left note: pulse N+1..N+4, busy low at N+7.
    send(20);
    chk("s1_left_n1", int'(move_left), 1);
    chk("s1_count", int'(move_count), 1);
    tick(); chk("s1_left_n2", int'(move_left), 1);
    tick(); chk("s1_left_n3", int'(move_left), 1);
    tick(); chk("s1_left_n4", int'(move_left), 1);
    tick(); chk("s1_left_n5", int'(move_left), 0);
    chk("s1_busy_n5", int'(busy), 1);
    tick(); chk("s1_busy_n6", int'(busy), 1);
    tick(); chk("s1_busy_n7", int'(busy), 0);

    // Held note after reset: one pulse only.
    do_reset();
    note_valid = 1'b1; note_in = 6'd20;
    count_rises(10, lr, rr);
    note_valid = 1'b0;
    count_rises(10, lr2, rr2);
    chk("s2_left_pulses", lr + lr2, 1);
    chk("s2_right_pulses", rr + rr2, 0);
    chk("s2_count", int'(move_count), 1);

    // Right note, then dead note, then repeated right note (last_note still 3).
    send(3);
    chk("s3_right_n1", int'(move_right), 1);
    count_rises(10, lr, rr);
    chk("s3_count", int'(move_count), 2);
    send(10);
    count_rises(8, lr, rr);
    chk("s3_dead_pulses", lr + rr, 0);
    send(3);
    count_rises(8, lr, rr);
    chk("s3_repeat_pulses", lr + rr, 0);
    chk("s3_count2", int'(move_count), 2);

    // Overwrite during a pulse, then direct chaining out of cooldown.
    send(20);
    chk("s4_left_e0", int'(move_left), 1);
    send(3);
    chk("s4_pending_e1", int'(pending), 1);
    chk("s4_ovw_e1", int'(overwrite), 0);
    send(30);
    chk("s4_ovw_e2", int'(overwrite), 1);
    chk("s4_pending_e2", int'(pending), 1);
    tick();
    chk("s4_ovw_e3", int'(overwrite), 0);
    chk("s4_left_e3", int'(move_left), 1);
    tick();
    chk("s4_left_e4", int'(move_left), 0);
    chk("s4_busy_e4", int'(busy), 1);
    tick();
    chk("s4_busy_e5", int'(busy), 1);
    chk("s4_right_e5", int'(move_right), 0);
    tick();
    chk("s4_left_e6", int'(move_left), 1);
    chk("s4_busy_e6", int'(busy), 1);
    chk("s4_pending_e6", int'(pending), 0);
    chk("s4_count", int'(move_count), 4);
    ov = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (overwrite) ov++;
    end
    chk("s4_ovw_late", ov, 0);
    wait_idle();

    // Reset in the second pulse cycle with a move queued.
    send(20);
    send(3);
    chk("s5_left_2nd", int'(move_left), 1);
    chk("s5_pending_2nd", int'(pending), 1);
    reset = 1'b1;
    #1;
    chk("s5_rst_left", int'(move_left), 0);
    chk("s5_rst_busy", int'(busy), 0);
    chk("s5_rst_pending", int'(pending), 0);
    chk("s5_rst_count", int'(move_count), 0);
    tick();
    reset = 1'b0;
    tick();
    send(20);
    chk("s5_left_after", int'(move_left), 1);
    chk("s5_count_after", int'(move_count), 1);
    count_rises(12, lr, rr);
    chk("s5_no_right", rr, 0);

    // 256 alternating notes wrap the 8-bit counter.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send((i % 2 == 0) ? 20 : 3);
      wait_idle();
      if (i == 254) chk("s6_count_255", int'(move_count), 255);
    end
    chk("s6_count_wrap", int'(move_count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/note_motion_fsm.md
NOTE_MOTION_FSM -- requirements
Module: note_motion_fsm

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 Parameters, one per line (name, default, meaning):
- NOTE_W, 6, note code width.
- LEFT_MIN, 15, lowest note code that commands a left move.
- RIGHT_MAX, 7, highest note code that commands a right move; legal range 1..LEFT_MIN-1.
- PULSE_LEN, 4, move-pulse length in cycles; minimum 1.
- COOLDOWN, 2, idle gap after each pulse in cycles; minimum 1.
- CNT_W, 8, move-counter width.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clock, in, 1, rising-edge system clock.
- reset, in, 1, async active-high reset.
- note_valid, in, 1, note_in is valid this cycle.
- note_in, in, NOTE_W, current note code; 0 = rest.
- move_left, out, 1, left-move pulse.
- move_right, out, 1, right-move pulse.
- busy, out, 1, high in MOVE_L, MOVE_R and COOLDOWN.
- pending, out, 1, one move is queued.
- overwrite, out, 1, one-cycle flag: a queued move was replaced.
- move_count, out, CNT_W, number of pulses started, wrapping.

Function
REQ-004 Note classification:
- LEFT if note_in >= LEFT_MIN.
- RIGHT if 1 <= note_in <= RIGHT_MAX.
- DEAD otherwise, including rest (0).
REQ-005 An accepted note is one with note_valid=1, class not DEAD, and either last_valid=0 or note_in != last_note.
REQ-006 On every accepted note, last_note SHALL load note_in and last_valid SHALL set.
REQ-007 DEAD notes SHALL change neither last_note nor the pending slot.
REQ-008 States:
- IDLE, MOVE_L, MOVE_R, COOLDOWN.
- Encodings SHALL be in a shared package.
REQ-009 IDLE: an accepted note at edge N SHALL move the FSM to MOVE_L or MOVE_R per its class; the pulse SHALL be high from cycle N+1.
REQ-010 MOVE_L and MOVE_R SHALL last exactly PULSE_LEN cycles, then go to COOLDOWN.
REQ-011 COOLDOWN SHALL last exactly COOLDOWN cycles with both pulses low.
REQ-012 COOLDOWN exit: after its last cycle, the FSM SHALL go directly to the queued direction's move state if pending=1, with pending clearing on that transition; otherwise it SHALL go to IDLE.
REQ-013 While busy, an accepted note SHALL be stored in the one-entry pending slot (direction only).
REQ-014 If the slot is already full, the new direction SHALL replace the old one and overwrite SHALL pulse high for one cycle.
REQ-015 If a note is accepted on the same edge the pending slot is consumed, the old entry SHALL be consumed and the new note SHALL be stored as pending, with no overwrite.
REQ-016 move_left and move_right SHALL be registered outputs and SHALL never be high together.
REQ-017 move_count SHALL increment on each entry into MOVE_L or MOVE_R and SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-018 While reset is high, the following SHALL hold:
- state = IDLE.
- move_left, move_right, busy, pending, overwrite = 0.
- move_count = 0.
- last_valid = 0.
- last_note = 0.
REQ-019 Reset asserted mid-pulse SHALL drop the pulse immediately and discard any pending move.
REQ-020 After reset, the first non-DEAD valid note SHALL be accepted, even if it equals the pre-reset last note.

Structure
REQ-021 The state encoding and a direction enum (NONE, LEFT, RIGHT) SHALL live in a shared package.
REQ-022 A sub-module note_classifier SHALL hold the combinational classification of REQ-004; the acceptance logic of REQ-005 SHALL stay in note_motion_fsm.
REQ-023 Timers SHALL use one down-counter of width clog2(max(PULSE_LEN, COOLDOWN)) + 1, shared by the move and COOLDOWN states.

Verification
REQ-024 The bench SHALL run these directed scenarios with default parameters:
- Note 20 valid for 1 cycle at edge N -> move_left high during cycles N+1..N+4; busy low at N+7; move_count = 1.
- Note 20 held valid for 10 cycles -> exactly one left pulse.
- Then note 3 -> one right pulse; then note 10 (DEAD) -> no pulse and last_note unchanged.
- During a left pulse, send 3 then 30 -> overwrite pulses once; a left pulse starts right after COOLDOWN with no IDLE cycle; pending clears.
- Reset asserted in the 2nd pulse cycle -> all outputs 0 the same cycle; after release, note 20 again -> left pulse.
- 256 distinct alternating notes 20/3 -> move_count wraps to 0; move_left and move_right never high together (assertion).
